htif_mem_master: RTL and testbench

- Host-side initiator for the HTIF write/read ports of the synchronous memory.
- Accepts burst read/write commands over valid/ready streams and drives hw_addr/hw_data/hw_mask/hw_en and hr_addr.
- Collects hr_data after the memory's fixed read latency into a credit-protected FIFO, so the non-stallable memory never overruns the host.
- Sits between the host/test-harness link and the memory's HTIF port pair.

---
 rtl/htif_mem_master_if.sv | 36 +++
 rtl/htif_mem_master.sv | 152 +++++++++++++++
 tb/tb_htif_mem_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/htif_mem_master_if.sv
// Host-side command / write-beat / read-beat streams of htif_mem_master.
// master = host (test harness link), slave = htif_mem_master.
interface htif_mem_master_if #(
  parameter int unsigned NUM_BYTES       = 1 << 21,
  parameter int unsigned DATA_WIDTH_HTIF = 32
);
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_BYTES);

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [ADDR_WIDTH-1:0]      req_addr;
  logic [7:0]                 req_len;

  logic                       wdata_valid;
  logic                       wdata_ready;
  logic [DATA_WIDTH_HTIF-1:0] wdata;

  logic                       rdata_valid;
  logic                       rdata_ready;
  logic [DATA_WIDTH_HTIF-1:0] rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata,
    output rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata,
    input  rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata
  );
endinterface

// File: rtl/htif_mem_master.sv
// htif_mem_master: host-side burst initiator for the memory's HTIF write/read
// port pair. Read returns land in a credit-protected FIFO so the fixed-latency,
// non-stallable memory can never overrun a stalled host.
// Optional: define HTIF_MEM_MASTER_ALIGN_CHECK_EN to consume-but-reject
// commands whose address is not beat aligned (err pulses for one cycle).
module htif_mem_master #(
  parameter  int unsigned NUM_BYTES       = 1 << 21,
  parameter  int unsigned DATA_WIDTH_HTIF = 32,
  parameter  int unsigned READ_LATENCY    = 2,
  parameter  int unsigned RFIFO_DEPTH     = 4,
  localparam int unsigned ADDR_WIDTH      = $clog2(NUM_BYTES),
  localparam int unsigned MASK_WIDTH      = DATA_WIDTH_HTIF / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  htif_mem_master_if.slave           host,
  output logic                       busy,
  output logic                       err,
  output logic [ADDR_WIDTH-1:0]      hw_addr,
  output logic [DATA_WIDTH_HTIF-1:0] hw_data,
  output logic [MASK_WIDTH-1:0]      hw_mask,
  output logic                       hw_en,
  output logic [ADDR_WIDTH-1:0]      hr_addr,
  input  logic [DATA_WIDTH_HTIF-1:0] hr_data
);
  localparam int unsigned PTR_W = $clog2(RFIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_e;

  state_e                     state_q;
  logic [ADDR_WIDTH-1:0]      cur_addr_q;
  logic [ADDR_WIDTH-1:0]      hr_addr_q;
  logic [8:0]                 beats_q;
  logic                       err_q;
  logic [READ_LATENCY-1:0]    tag_q, tag_d;
  logic [DATA_WIDTH_HTIF-1:0] fifo_q [RFIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [CNT_W-1:0]           inflight;
  logic [CNT_W:0]             credit_sum;
  logic                       issue, wr_fire, push, pop, last_beat, misaligned;

`ifdef HTIF_MEM_MASTER_ALIGN_CHECK_EN
  assign misaligned = (host.req_addr & ADDR_WIDTH'(MASK_WIDTH - 1)) != '0;
`else
  assign misaligned = 1'b0;
`endif

  // Credit, issue/accept strobes, tag shift and FIFO occupancy next-state.
  always_comb begin
    inflight   = CNT_W'($countones(tag_q));
    credit_sum = {1'b0, count_q} + {1'b0, inflight};
    issue      = (state_q == RD) && (credit_sum < (CNT_W + 1)'(RFIFO_DEPTH));
    wr_fire    = (state_q == WR) && host.wdata_valid;
    last_beat  = (beats_q == 9'd1);
    push       = tag_q[READ_LATENCY-1];
    pop        = (count_q != '0) && host.rdata_ready;
    tag_d      = '0;
    tag_d[0]   = issue;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign host.req_ready   = (state_q == IDLE);
  assign host.wdata_ready = (state_q == WR);
  assign host.rdata_valid = (count_q != '0);
  assign host.rdata       = fifo_q[rd_ptr_q];

  assign hw_en   = wr_fire;
  assign hw_addr = wr_fire ? cur_addr_q : '0;
  assign hw_data = wr_fire ? host.wdata : '0;
  assign hw_mask = wr_fire ? '1 : '0;

  // hr_addr is only meaningful on issue cycles; otherwise it holds so idle
  // memory reads stay quiet (they are untagged and never captured).
  assign hr_addr = issue ? cur_addr_q : hr_addr_q;

  assign busy = (state_q != IDLE) || (tag_q != '0) || (count_q != '0);
  assign err  = err_q;

  // Burst control FSM: command latch, beat/issue counting, address advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      beats_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (host.req_valid) begin
            if (misaligned) begin
              err_q <= 1'b1;
            end else begin
              cur_addr_q <= host.req_addr;
              beats_q    <= {1'b0, host.req_len} + 9'd1;
              state_q    <= host.req_write ? WR : RD;
            end
          end
        end
        WR: begin
          if (wr_fire) begin
            cur_addr_q <= cur_addr_q + ADDR_WIDTH'(MASK_WIDTH);
            beats_q    <= beats_q - 9'd1;
            if (last_beat) state_q <= IDLE;
          end
        end
        RD: begin
          if (issue) begin
            cur_addr_q <= cur_addr_q + ADDR_WIDTH'(MASK_WIDTH);
            beats_q    <= beats_q - 9'd1;
            if (last_beat) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (tag_q == '0) state_q <= IDLE;
        end
      endcase
    end
  end

  // Read-return tracking: held read address, latency tags, FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr_addr_q <= '0;
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      hr_addr_q <= hr_addr;
      tag_q     <= tag_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; the push is unconditional because credit reserved the slot.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= hr_data;
  end
endmodule

// File: tb/tb_htif_mem_master.sv
// Scoreboard bench for htif_mem_master: a behavioural memory drives the HTIF
// ports, a reference word map predicts every write and read-return beat.
module tb_htif_mem_master;
  localparam int unsigned NB    = 1 << 21;
  localparam int unsigned DW    = 32;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(NB);
  localparam int unsigned MW    = DW / 8;
  localparam int unsigned BOUND = 2000;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          busy, err, hw_en;
  logic [AW-1:0] hw_addr, hr_addr;
  logic [DW-1:0] hw_data, hr_data;
  logic [MW-1:0] hw_mask;

  htif_mem_master_if #(.NUM_BYTES(NB), .DATA_WIDTH_HTIF(DW)) h ();

  htif_mem_master #(
    .NUM_BYTES(NB), .DATA_WIDTH_HTIF(DW), .READ_LATENCY(RL), .RFIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .host(h), .busy(busy), .err(err),
    .hw_addr(hw_addr), .hw_data(hw_data), .hw_mask(hw_mask), .hw_en(hw_en),
    .hr_addr(hr_addr), .hr_data(hr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Synchronous memory: writes land on the edge, reads return RL cycles later.
  logic [DW-1:0] sim_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_pipe [RL];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : '0;
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd(hr_addr);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (hw_en) sim_mem[hw_addr] = hw_data;
  end
  assign hr_data = rd_pipe[RL-1];

  // Reference contents and expectation queues.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_rd [$];
  logic [AW-1:0] exp_wa [$];
  logic [DW-1:0] exp_wd [$];
  logic [DW-1:0] wq [$];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Monitor: checks every memory write and every delivered read beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (!(h.wdata_valid && h.wdata_ready)) check("hw_en_without_beat", hw_en, 0);
      if (hw_en) begin
        if (exp_wa.size() == 0) report_fail("unexpected_hw_write");
        else begin
          check("hw_addr", hw_addr, exp_wa.pop_front());
          check("hw_data", hw_data, exp_wd.pop_front());
          check("hw_mask", hw_mask, {MW{1'b1}});
        end
      end
      if (h.rdata_valid && h.rdata_ready) begin
        if (exp_rd.size() == 0) report_fail("unexpected_rdata_beat");
        else check("rdata", h.rdata, exp_rd.pop_front());
      end
`ifndef HTIF_MEM_MASTER_ALIGN_CHECK_EN
      check("err_tied_low", err, 0);
`endif
    end
  end

  // Host read-side acceptance: 0 always ready, 1 random, 2 held off.
  int rd_mode = 0;
  initial begin
    h.rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0:       h.rdata_ready = 1'b1;
        1:       h.rdata_ready = 1'($urandom_range(0, 1));
        default: h.rdata_ready = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [7:0] len);
    int unsigned n = 0;
    h.req_valid = 1'b1;
    h.req_write = wr;
    h.req_addr  = a;
    h.req_len   = len;
    while (!h.req_ready && n < BOUND) begin
      step();
      n++;
    end
    if (!h.req_ready) report_fail("req_handshake_timeout");
    step();
    h.req_valid = 1'b0;
  endtask

  // gap_mode: 0 none, 1 idle cycle between beats, 2 random idle cycles.
  task automatic do_write(input logic [AW-1:0] a, input int unsigned gap_mode);
    int unsigned n;
    logic [AW-1:0] ba;
    for (int unsigned i = 0; i < wq.size(); i++) begin
      ba = a + AW'(i * MW);
      exp_wa.push_back(ba);
      exp_wd.push_back(wq[i]);
      ref_mem[ba] = wq[i];
    end
    send_cmd(1'b1, a, 8'(wq.size() - 1));
    for (int unsigned i = 0; i < wq.size(); i++) begin
      if ((gap_mode == 1 && i != 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        h.wdata_valid = 1'b0;
        step();
      end
      h.wdata_valid = 1'b1;
      h.wdata       = wq[i];
      n = 0;
      while (!h.wdata_ready && n < BOUND) begin
        step();
        n++;
      end
      if (!h.wdata_ready) begin
        report_fail("wdata_accept_timeout");
        break;
      end
      step();
    end
    h.wdata_valid = 1'b0;
    if (gap_mode == 1) check("busy_after_last_beat", busy, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [7:0] len);
    for (int unsigned i = 0; i <= len; i++) exp_rd.push_back(ref_rd(a + AW'(i * MW)));
    send_cmd(1'b0, a, len);
  endtask

  task automatic fill_wq(input int unsigned beats);
    wq.delete();
    for (int unsigned i = 0; i < beats; i++) wq.push_back($urandom);
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((busy || exp_rd.size() != 0) && n < BOUND) begin
      step();
      n++;
    end
    check({name, "_busy_clear"}, busy, 0);
    check({name, "_reads_delivered"}, exp_rd.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    h.req_valid   = 1'b0;
    h.req_write   = 1'b0;
    h.req_addr    = '0;
    h.req_len     = '0;
    h.wdata_valid = 1'b0;
    h.wdata       = '0;
    step();
    step();
    check("rst_req_ready", h.req_ready, 1);
    check("rst_wdata_ready", h.wdata_ready, 0);
    check("rst_rdata_valid", h.rdata_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_hw_en", hw_en, 0);
    check("rst_hw_addr", hw_addr, 0);
    check("rst_hw_data", hw_data, 0);
    check("rst_hw_mask", hw_mask, 0);
    check("rst_hr_addr", hr_addr, 0);
    reset = 1'b0;
    step();

    // Write 4 known words at 0x100, then read them back.
    wq.delete();
    for (int unsigned i = 1; i <= 4; i++) wq.push_back(DW'(i) * 32'h1111_1111);
    do_write(AW'(32'h100), 0);
    do_read(AW'(32'h100), 8'd3);
    wait_idle("write_read");

    // Backpressure: 16-beat read with the host stalled.
    fill_wq(16);
    do_write(AW'(32'h200), 0);
    wait_idle("bp_prefill");
    rd_mode = 2;
    step();
    step();
    do_read(AW'(32'h200), 8'd15);
    repeat (30) step();
    check("bp_rdata_valid", h.rdata_valid, 1);
    check("bp_busy", busy, 1);
    check("bp_req_ready", h.req_ready, 0);
    check("bp_issue_stops_at_depth", hr_addr, AW'(32'h200 + (DEPTH - 1) * MW));
    rd_mode = 0;
    wait_idle("bp_release");

    // Burst wrapping through the top of the address space.
    fill_wq(2);
    do_write(AW'(NB - 4), 0);
    do_read(AW'(NB - 4), 8'd1);
    wait_idle("wrap");

    // Write with an idle cycle between every beat.
    fill_wq(6);
    do_write(AW'(32'h300), 1);
    do_read(AW'(32'h300), 8'd5);
    wait_idle("write_stall");

    // Reset with two reads in flight.
    rd_mode = 2;
    step();
    step();
    do_read(AW'(32'h100), 8'd7);
    step();
    step();
    #1 reset = 1'b1;
    #1;
    check("midrst_rdata_valid", h.rdata_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", h.req_ready, 1);
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    step();
    step();
    reset = 1'b0;
    rd_mode = 0;
    step();
    do_read(AW'(32'h100), 8'd3);
    wait_idle("after_reset_read");

    // Randomized mix of bursts with host stalls on both sides.
    rd_mode = 1;
    for (int unsigned it = 0; it < 24; it++) begin
      logic [AW-1:0] ra;
      logic [7:0]    rl;
      ra = AW'(32'h1000 + 4 * $urandom_range(0, 31));
      rl = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        fill_wq(int'(rl) + 1);
        do_write(ra, 2);
      end else begin
        do_read(ra, rl);
      end
    end
    rd_mode = 0;
    wait_idle("random");

`ifdef HTIF_MEM_MASTER_ALIGN_CHECK_EN
    // Misaligned write: consumed, rejected with an err pulse, no beats taken.
    h.wdata_valid = 1'b1;
    h.wdata       = 32'hDEAD_BEEF;
    send_cmd(1'b1, AW'(32'h102), 8'd0);
    check("align_err_pulse", err, 1);
    check("align_wdata_ready", h.wdata_ready, 0);
    step();
    check("align_err_one_cycle", err, 0);
    repeat (4) begin
      check("align_no_wdata_ready", h.wdata_ready, 0);
      step();
    end
    h.wdata_valid = 1'b0;
    check("align_busy", busy, 0);
    check("align_req_ready", h.req_ready, 1);
`endif

    wait_idle("final");
    check("final_writes_done", exp_wa.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
